// File: rtl/load_store_unit.sv
// RV32I load/store stage: turns an ALU effective address plus rs2 into one
// req/gnt/rvalid data-memory access with byte-lane steering and load extension.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_illegal,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              illegal_c, misalign_c;
  logic              accept;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_c;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign accept = (state_q == IDLE) && req_valid;

  // Illegal funct3 wins over misalignment so only one error flag is ever raised.
  always_comb begin
    illegal_c  = 1'b1;
    misalign_c = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
      3'b100, 3'b101:         illegal_c = req_we;
      default:                illegal_c = 1'b1;
    endcase
    if (!illegal_c) begin
      case (req_funct3[1:0])
        2'b01:   misalign_c = req_addr[0];
        2'b10:   misalign_c = |req_addr[1:0];
        default: misalign_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (illegal_c || misalign_c) ? RESP : REQ;
      REQ:  if (mem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request fields are frozen at accept so mem_* stay stable through a slow grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else if (accept) begin
      we_q         <= req_we;
      funct3_q     <= req_funct3;
      addr_q       <= req_addr;
      wdata_q      <= req_wdata;
      rsp_rdata    <= '0;
      rsp_misalign <= misalign_c;
      rsp_illegal  <= illegal_c;
    end else if (state_q == WAIT && mem_rvalid) begin
      rsp_rdata    <= load_c;
    end
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_c = mem_rdata;
    case (funct3_q)
      3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_c = {24'd0, byte_sel};
      3'b101:  load_c = {16'd0, half_sel};
      default: load_c = mem_rdata;
    endcase
  end

  // Memory-side outputs are forced to zero outside REQ so idle/reset looks clean.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_c : 4'b0000;
  assign mem_wdata = mem_req ? wdata_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against an arithmetic reference model of the access rules.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        rsp_illegal;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .rsp_illegal(rsp_illegal),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: access rules expressed as plain arithmetic on sizes/offsets.
  function automatic bit mdlIllegal(bit we, int f3);
    if (we) return !(f3 inside {0, 1, 2});
    return !(f3 inside {0, 1, 2, 4, 5});
  endfunction

  function automatic int mdlSize(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit mdlMisalign(bit we, int f3, logic [31:0] addr);
    if (mdlIllegal(we, f3)) return 1'b0;
    return (addr % mdlSize(f3)) != 0;
  endfunction

  function automatic logic [3:0] mdlBe(int f3, logic [31:0] addr);
    int sz = mdlSize(f3);
    if (sz == 4) return 4'd15;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] mdlWdata(int f3, logic [31:0] wd);
    int sz = mdlSize(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] mdlLoad(int f3, logic [31:0] addr, logic [31:0] rd);
    int sz = mdlSize(f3);
    logic [31:0] v;
    logic [31:0] lim;
    if (sz == 4) return rd;
    v   = rd >> (8 * (addr % 4));
    lim = 32'd1 << (8 * sz);
    v   = v % lim;
    if (f3 < 4 && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  // One full core transaction; the core holds req_valid until rsp_valid.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                               input logic [31:0] rd, input bit noise);
    bit ill, mis;
    int cyc;
    ill = mdlIllegal(we, int'(f3));
    mis = mdlMisalign(we, int'(f3), addr);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    cyc = 1;
    if (ill || mis) begin
      checkOutput("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("err_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
      checkOutput("err_misalign", {31'd0, rsp_misalign}, {31'd0, mis});
      checkOutput("err_rdata", rsp_rdata, 32'd0);
      checkOutput("err_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        mem_gnt    = (i == gnt_dly);
        mem_rvalid = noise && (i != gnt_dly);
        mem_rdata  = $urandom;
        checkOutput("mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, we});
        checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("mem_be", {28'd0, mem_be}, {28'd0, mdlBe(int'(f3), addr)});
        if (we) checkOutput("mem_wdata", mem_wdata, mdlWdata(int'(f3), wd));
        checkOutput("rsp_valid_busy", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        cyc++;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!we) begin
        checkOutput("wait_mem_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i <= rv_dly; i++) begin
          mem_rvalid = (i == rv_dly);
          mem_rdata  = (i == rv_dly) ? rd : $urandom;
          checkOutput("rsp_valid_wait", {31'd0, rsp_valid}, 32'd0);
          @(posedge clk); #1;
          cyc++;
        end
        mem_rvalid = 1'b0;
        checkOutput("ld_latency", cyc, gnt_dly + 3 + rv_dly);
        checkOutput("ld_rdata", rsp_rdata, mdlLoad(int'(f3), addr, rd));
      end else begin
        checkOutput("st_latency", cyc, gnt_dly + 2);
        checkOutput("st_rdata", rsp_rdata, 32'd0);
      end
      checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("rsp_flags", {30'd0, rsp_illegal, rsp_misalign}, 32'd0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_1234, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_1234, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_1002, 32'd0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h0000_1000, 32'd0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h0000_1001, 32'd0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h0000_1002, 32'd0, 3, 0, 32'h8001_0000, 1'b1);
    applyStimulus(1'b0, 3'b101, 32'h0000_1003, 32'd0, 0, 0, 32'd0, 1'b0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) != 0) ? 3'b100 : 3'b000);
      applyStimulus(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                    1'($urandom_range(0, 1)));
    end

    $display("[TB] reset while waiting for read data");
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b001;
    req_addr   = 32'h0000_1002;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("wait_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    req_valid = 1'b0;
    checkOutput("arst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("arst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
    checkOutput("late_rvalid_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    checkOutput("late_rvalid_rsp2", {31'd0, rsp_valid}, 32'd0);
    checkOutput("late_rvalid_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] reset while requesting");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_3000;
    req_wdata  = 32'h1234_5678;
    @(posedge clk); #1;
    checkOutput("req_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    req_valid = 1'b0;
    checkOutput("arst2_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("arst2_mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("arst2_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_3000, 32'd0, 1, 1, 32'hCAFE_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
